// File: rtl/rst_req_gen_if.sv
// ============================================================================
// Module : rst_req_gen_if
// Purpose: Groups the request/status signals of the reset request generator.
//   Sw_Rst_Req  : synchronous software reset request (master -> slave)
//   Ext_Rst_n   : raw active-low reset button           (master -> slave)
//   Rst_Out_n   : generated active-low reset            (slave -> master)
//   Busy        : pulse or hold-off in progress         (slave -> master)
//   Rst_Count   : request-triggered pulses, saturating  (slave -> master)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface rst_req_gen_if;
  logic       Sw_Rst_Req;
  logic       Ext_Rst_n;
  logic       Rst_Out_n;
  logic       Busy;
  logic [7:0] Rst_Count;

  modport master (
    output Sw_Rst_Req,
    output Ext_Rst_n,
    input  Rst_Out_n,
    input  Busy,
    input  Rst_Count
  );

  modport slave (
    input  Sw_Rst_Req,
    input  Ext_Rst_n,
    output Rst_Out_n,
    output Busy,
    output Rst_Count
  );
endinterface

`default_nettype wire

// File: rtl/rst_req_gen.sv
// ============================================================================
// Module : rst_req_gen
// Purpose: Merges a software reset request and a bouncing external reset
//          button into one clean, stretched, active-low reset pulse with a
//          minimum width and a hold-off window between pulses.
// Ports  :
//   CLK          in   reference clock, rising edge
//   Async_Reset  in   asynchronous active-high block reset
//   bus.Sw_Rst_Req  in   software request, sampled every edge
//   bus.Ext_Rst_n   in   asynchronous active-low button
//   bus.Rst_Out_n   out  registered active-low reset
//   bus.Busy        out  1 during ASSERT or HOLDOFF
//   bus.Rst_Count   out  request-triggered pulses, saturates at 255
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_req_gen #(
  parameter int PULSE_CYCLES    = 8,
  parameter int HOLDOFF_CYCLES  = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  wire logic     CLK,
  input  wire logic     Async_Reset,
  rst_req_gen_if.slave  bus
);

  localparam int c_MAX_CYC = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int c_CNT_W   = $clog2(c_MAX_CYC) + 1;
  localparam int c_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [c_CNT_W-1:0] c_PULSE_LAST = c_CNT_W'(PULSE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [c_DB_W-1:0]  c_DB_LAST    = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_DB_W-1:0]  c_DB_FULL    = c_DB_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_pending;
  logic                 r_rst_n;
  logic                 r_busy;
  logic [7:0]           r_count;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [c_DB_W-1:0]      r_db_cnt;
  logic                   r_armed;

  logic       w_s;
  logic       w_ext_press;
  logic       w_req;
  logic [7:0] w_count_inc;

  // --------------------------------------------------------------------------
  // Button path: synchronizer then debounce. The press fires combinationally
  // on the edge where the low-run reaches DEBOUNCE_CYCLES so the FSM reacts on
  // that same edge; armed blocks repeats until the button is released.
  // --------------------------------------------------------------------------
  assign w_s         = r_sync[SYNC_STAGES-1];
  assign w_ext_press = ~w_s & r_armed & (r_db_cnt == c_DB_LAST);
  assign w_req       = bus.Sw_Rst_Req | w_ext_press;
  assign w_count_inc = (r_count == 8'hFF) ? r_count : r_count + 8'd1;

  always_ff @(posedge CLK or posedge Async_Reset) begin
    if (Async_Reset) begin
      r_sync   <= '1;
      r_db_cnt <= '0;
      r_armed  <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.Ext_Rst_n};
      if (w_s) begin
        r_db_cnt <= '0;
        r_armed  <= 1'b1;
      end else begin
        if (r_db_cnt != c_DB_FULL) r_db_cnt <= r_db_cnt + 1'b1;
        if (w_ext_press)           r_armed  <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pulse FSM. Reset lands in ASSERT so the power-on pulse comes for free and
  // is not counted.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge Async_Reset) begin
    if (Async_Reset) begin
      r_state   <= ST_ASSERT;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_rst_n   <= 1'b0;
      r_busy    <= 1'b1;
      r_count   <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_state <= ST_ASSERT;
            r_cnt   <= '0;
            r_rst_n <= 1'b0;
            r_busy  <= 1'b1;
            r_count <= w_count_inc;
          end
        end
        ST_ASSERT: begin
          if (r_cnt == c_PULSE_LAST) begin
            r_state <= ST_HOLDOFF;
            r_cnt   <= '0;
            r_rst_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (r_cnt == c_HOLD_LAST) begin
            // A request on the exit edge is treated as pending.
            r_pending <= 1'b0;
            r_cnt     <= '0;
            if (r_pending | w_req) begin
              r_state <= ST_ASSERT;
              r_rst_n <= 1'b0;
              r_count <= w_count_inc;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_req) r_pending <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          r_pending <= 1'b0;
          r_rst_n   <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Rst_Out_n = r_rst_n;
  assign bus.Busy      = r_busy;
  assign bus.Rst_Count = r_count;

endmodule

`default_nettype wire
